// File: rtl/uart_genome_dumper.sv
// UART 8N1 readback of the active genome as a 42-byte frame:
// "ATOM", version, freq (LE), policy, DNA[32]. Inputs are snapshotted at start acceptance.
module uart_genome_dumper #(
  parameter int          CLK_FREQ  = 27000000,
  parameter int          BAUD_RATE = 115200,
  parameter logic [7:0]  VERSION   = 8'h01
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dump_start,
  input  logic [31:0]  poly_freq_in,
  input  logic         otp_en_in,
  input  logic [255:0] dna_in,
  output logic         uart_tx,
  output logic         dump_busy,
  output logic         dump_done,
  output logic [5:0]   byte_idx_out
);

  localparam int             CLK_DIV   = CLK_FREQ / BAUD_RATE;
  localparam int             CW        = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0]  DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [5:0]     LAST_BYTE = 6'd41;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_baud_cnt;
  logic [2:0]     r_bit_idx;
  logic [5:0]     r_byte_idx;
  logic [31:0]    r_freq;
  logic           r_otp;
  logic [255:0]   r_dna;
  logic           r_tx;
  logic           r_busy;
  logic           r_done;

  logic [7:0]     w_byte;
  logic [4:0]     w_dna_sel;
  logic           w_bit_end;
  logic [2:0]     w_next_bit;

  // DNA bytes live at frame index 10..41; the 5-bit wrap maps them to 0..31.
  assign w_dna_sel  = r_byte_idx[4:0] - 5'd10;
  assign w_bit_end  = (r_baud_cnt == DIV_LAST);
  assign w_next_bit = r_bit_idx + 3'd1;

  always_comb begin
    w_byte = r_dna[{w_dna_sel, 3'b000} +: 8];
    case (r_byte_idx)
      6'd0:    w_byte = 8'h41;
      6'd1:    w_byte = 8'h54;
      6'd2:    w_byte = 8'h4F;
      6'd3:    w_byte = 8'h4D;
      6'd4:    w_byte = VERSION;
      6'd5:    w_byte = r_freq[7:0];
      6'd6:    w_byte = r_freq[15:8];
      6'd7:    w_byte = r_freq[23:16];
      6'd8:    w_byte = r_freq[31:24];
      6'd9:    w_byte = {7'b0, r_otp};
      default: w_byte = r_dna[{w_dna_sel, 3'b000} +: 8];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_freq     <= '0;
      r_otp      <= 1'b0;
      r_dna      <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx       <= 1'b1;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_byte_idx <= '0;
          r_bit_idx  <= '0;
          r_baud_cnt <= '0;
          if (dump_start) begin
            r_freq  <= poly_freq_in;
            r_otp   <= otp_en_in;
            r_dna   <= dna_in;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_tx       <= w_byte[0];
            r_state    <= S_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= w_next_bit;
              r_tx      <= w_byte[w_next_bit];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_byte_idx < LAST_BYTE) begin
              // Back-to-back bytes: next start bit follows the stop bit directly.
              r_byte_idx <= r_byte_idx + 6'd1;
              r_tx       <= 1'b0;
              r_state    <= S_START;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_done     <= 1'b0;
          r_byte_idx <= '0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign uart_tx      = r_tx;
  assign dump_busy    = r_busy;
  assign dump_done    = r_done;
  assign byte_idx_out = r_byte_idx;

endmodule
